// File: rtl/mmu_pkg.sv
// Shared MMU definitions: DAT engine state encoding, op codes, DAT geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmu_pkg;

    // Engine sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL_WR = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_DONE    = 3'd4
    } eng_state_t;

    // Command op codes, sampled with start
    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    // One DAT entry per 8K page, eight pages per task
    localparam int DAT_ENTRIES = 8;
    localparam int DAT_DATA_W  = 16;

    // DAT address is {task, entry}
    function automatic int dat_addr_w(input int task_bits, input int entry_bits);
        return task_bits + entry_bits;
    endfunction

endpackage

// File: rtl/dat_arbiter.sv
// Muxes the CPU/MMU path and the DAT task engine onto the shared DAT SRAM pins.
// Latency: combinational.
// Backpressure: CPU always wins; the engine only reaches the pins when granted.
module dat_arbiter #(
    parameter int ADDR_W = 15
) (
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [15:0]       i_cpu_wdata,
    input  logic              i_cpu_we_l,
    input  logic              i_cpu_we_h,
    input  logic              i_eng_grant,
    input  logic [ADDR_W-1:0] i_eng_addr,
    input  logic [15:0]       i_eng_wdata,
    input  logic              i_eng_we_l,
    input  logic              i_eng_we_h,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    output logic              o_sram_we_l,
    output logic              o_sram_we_h
);

    // CPU path first, engine only when it holds the grant, otherwise idle pins
    always_comb begin
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_we_l  = 1'b0;
        o_sram_we_h  = 1'b0;
        if (i_cpu_req) begin
            o_sram_addr  = i_cpu_addr;
            o_sram_wdata = i_cpu_wdata;
            o_sram_we_l  = i_cpu_we_l;
            o_sram_we_h  = i_cpu_we_h;
        end else if (i_eng_grant) begin
            o_sram_addr  = i_eng_addr;
            o_sram_wdata = i_eng_wdata;
            o_sram_we_l  = i_eng_we_l;
            o_sram_we_h  = i_eng_we_h;
        end
    end

endmodule

// File: rtl/register.sv
// Generic enable-load register with synchronous active-high clear.
// Latency: 1 cycle from i_en to o_q.
// Backpressure: none; loads whenever i_en is high.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Clear on reset, otherwise load when enabled
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/dat_task_engine.sv
// Bulk FILL / COPY sequencer for one task's eight DAT entries, sharing the SRAM with the CPU.
// Latency: FILL done 9 cycles after start, COPY 17, plus one cycle per cpu_req stall.
// Backpressure: cpu_req freezes the current step; start is ignored unless IDLE.
module dat_task_engine
    import mmu_pkg::*;
#(
    parameter int TASK_BITS  = 12,
    parameter int ENTRY_BITS = 3
) (
    input  logic                            i_e,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic                            i_op,
    input  logic                            i_ext,
    input  logic [TASK_BITS-1:0]            i_src_task,
    input  logic [TASK_BITS-1:0]            i_dst_task,
    input  logic [15:0]                     i_fill_base,
    input  logic                            i_cpu_req,
    output logic                            o_grant,
    output logic [TASK_BITS+ENTRY_BITS-1:0] o_dat_addr,
    output logic [15:0]                     o_dat_wdata,
    input  logic [15:0]                     i_dat_rdata,
    output logic                            o_dat_we_l,
    output logic                            o_dat_we_h,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int ADDR_W = dat_addr_w(TASK_BITS, ENTRY_BITS);
    // Command latch holds {ext, src, dst, base}; op is carried by the state itself
    localparam int CMD_W  = 1 + 2 * TASK_BITS + DAT_DATA_W;
    localparam logic [ENTRY_BITS-1:0] LAST_IDX = ENTRY_BITS'(DAT_ENTRIES - 1);

    eng_state_t              r_state;
    logic [ENTRY_BITS-1:0]   r_idx;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_start_acc;
    logic                    w_active;
    logic                    w_grant;
    logic                    w_last;
    logic [CMD_W-1:0]        w_cmd_d;
    logic [CMD_W-1:0]        w_cmd_q;
    logic                    w_ext;
    logic [TASK_BITS-1:0]    w_src;
    logic [TASK_BITS-1:0]    w_dst;
    logic [15:0]             w_base;
    logic [15:0]             w_hold;
    logic                    w_hold_en;
    logic [15:0]             w_fill_data;
    logic [ADDR_W-1:0]       w_dat_addr;
    logic [15:0]             w_dat_wdata;
    logic                    w_we_l;
    logic                    w_we_h;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_active    = (r_state == ST_FILL_WR) || (r_state == ST_COPY_RD) ||
                         (r_state == ST_COPY_WR);
    assign w_grant     = w_active && !i_cpu_req;
    assign w_last      = (r_idx == LAST_IDX);

    assign w_cmd_d = {i_ext, i_src_task, i_dst_task, i_fill_base};
    assign {w_ext, w_src, w_dst, w_base} = w_cmd_q;

    register #(.WIDTH(CMD_W)) u_cmd_latch (
        .i_clk   (i_e),
        .i_reset (i_reset),
        .i_en    (w_start_acc),
        .i_d     (w_cmd_d),
        .o_q     (w_cmd_q)
    );

    // Source word is captured only on a granted read, so a write stall never re-reads it
    assign w_hold_en = w_grant && (r_state == ST_COPY_RD);

    register #(.WIDTH(DAT_DATA_W)) u_hold (
        .i_clk   (i_e),
        .i_reset (i_reset),
        .i_en    (w_hold_en),
        .i_d     (i_dat_rdata),
        .o_q     (w_hold)
    );

    assign w_fill_data = w_base + 16'(r_idx);

    // Sequencer: one step per cycle without cpu_req, frozen while cpu_req is high
    always_ff @(posedge i_e) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (i_op == OP_COPY) ? ST_COPY_RD : ST_FILL_WR;
                    end
                end
                ST_FILL_WR: begin
                    if (!i_cpu_req) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_COPY_RD: begin
                    if (!i_cpu_req) begin
                        r_state <= ST_COPY_WR;
                    end
                end
                ST_COPY_WR: begin
                    if (!i_cpu_req) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_COPY_RD;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM address, data and strobes decoded from the current step; strobes need the grant
    always_comb begin
        w_dat_addr  = '0;
        w_dat_wdata = '0;
        w_we_l      = 1'b0;
        w_we_h      = 1'b0;
        case (r_state)
            ST_FILL_WR: begin
                w_dat_addr  = {w_dst, r_idx};
                w_dat_wdata = w_fill_data;
                w_we_l      = w_grant;
                w_we_h      = w_grant && w_ext;
            end
            ST_COPY_RD: begin
                w_dat_addr  = {w_src, r_idx};
            end
            ST_COPY_WR: begin
                w_dat_addr  = {w_dst, r_idx};
                w_dat_wdata = w_hold;
                w_we_l      = w_grant;
                w_we_h      = w_grant && w_ext;
            end
            default: begin
                w_dat_addr  = '0;
            end
        endcase
    end

    assign o_grant     = w_grant;
    assign o_dat_addr  = w_dat_addr;
    assign o_dat_wdata = w_dat_wdata;
    assign o_dat_we_l  = w_we_l;
    assign o_dat_we_h  = w_we_h;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: doc/dat_task_engine.md
# dat_task_engine

Sequencer that bulk-programs the DAT task RAM (the 32K x 16 MMU translation SRAM) on behalf of system software, sharing that SRAM with the CPU-side MMU path. It performs two operations: FILL, an identity-style fill of one task's 8 bank entries, and COPY, which copies one task's 8 entries to another. The CPU path always has priority, and the engine only drives the DAT SRAM in cycles where `cpu_req` is low. It sits beside the MMU core, and its DAT address/data/strobe outputs are muxed in when `grant` is high.

## Interface
- `TASK_BITS`, default 12: task number width; DAT address is {task, entry}.
- `ENTRY_BITS`, default 3: entry index width; 8 entries per task, one per 8K page.
- `e`  in  1: clock, the CPU E clock. All logic is on the rising edge.
- `reset`  in  1: reset; one clock; reset is synchronous and active-high.
- `start`  in  1: one-cycle command strobe. Honoured only in IDLE.
- `op`  in  1: 0 = FILL, 1 = COPY. Sampled with `start`.
- `ext`  in  1: 1 = write both bytes (16-bit entries), 0 = low byte only. Sampled with `start`.
- `src_task`  in  TASK_BITS: COPY source task.
- `dst_task`  in  TASK_BITS: destination task.
- `fill_base`  in  16: FILL value for entry 0. Entry i receives `fill_base + i`, mod 2^16.
- `cpu_req`  in  1: the CPU/MMU path needs the DAT SRAM this cycle.
- `grant`  out  1: the engine owns the DAT SRAM this cycle.
- `dat_addr`  out  TASK_BITS+ENTRY_BITS: DAT address.
- `dat_wdata`  out  16: write data.
- `dat_rdata`  in  16: asynchronous SRAM read data.
- `dat_we_l`, `dat_we_h`  out  1 each: active-high byte write strobes. Valid only when `grant` is high.
- `busy`  out  1: high from the cycle after an accepted `start` until DONE.
- `done`  out  1: one-cycle pulse on completion.

## Operation
- States: IDLE, FILL_WR, COPY_RD, COPY_WR, DONE.
- IDLE:
  - On `start`, latch op, ext, src_task, dst_task and fill_base, and clear entry counter `idx` to 0.
  - Go to FILL_WR if op = 0, otherwise COPY_RD.
- FILL_WR:
  - `dat_addr` = {dst, idx}. `dat_wdata` = base + idx (16-bit add, wraps).
  - `dat_we_l` = 1. `dat_we_h` = ext.
  - On a granted cycle, increment `idx`. After idx = 7 is written, go to DONE.
- COPY_RD:
  - `dat_addr` = {src, idx}, no strobes.
  - On a granted cycle, capture `dat_rdata` into the holding register `hold`, then go to COPY_WR.
- COPY_WR:
  - `dat_addr` = {dst, idx}, `dat_wdata` = `hold`, strobes as in FILL.
  - On a granted cycle: if idx = 7, go to DONE; otherwise increment idx and go to COPY_RD.
- DONE: `done` = 1 for one cycle, `busy` = 0, then go to IDLE.
- Arbitration:
  - `grant` = !`cpu_req` and state is one of FILL_WR, COPY_RD, COPY_WR.
  - While `cpu_req` is high: strobes are 0, the state, `idx` and `hold` are frozen, and the operation retries the same step in the next free cycle.
  - A stall during COPY_WR never re-reads the source.
- `src_task` = `dst_task` in COPY: legal. Each entry is rewritten with its own value.
- `start` while busy or in DONE is ignored. No queueing.
- `idx` is ENTRY_BITS wide and wraps 7 -> 0 only at completion. `fill_base + idx` is zero-extended to 16 bits.

## Timing
- Reset values:
  - state = IDLE, `idx` = 0, `hold` = 0.
  - `busy`, `done`, `grant`, `dat_we_l`, `dat_we_h` = 0.
  - `dat_addr` = 0, `dat_wdata` = 0.
- Reset mid-operation aborts immediately:
  - No further strobes.
  - Entries already written stay written.
  - No `done` pulse.
- Strobes, address and data are combinational from registered state and `cpu_req`. A write occurs in the same cycle `grant` is high.
- Latency with no contention:
  - FILL: `start` at cycle 0, writes in cycles 1-8, `done` in cycle 9.
  - COPY: `start` at cycle 0, read/write pairs in cycles 1-16, `done` in cycle 17.
- Each cycle with `cpu_req` high during an active step adds exactly one cycle.
- `start` arriving in the same cycle as `done` is ignored. It is accepted again from the next cycle.

## Structure
- Shared package `mmu_pkg`:
  - State encoding.
  - OP_FILL / OP_COPY constants.
  - DAT_ENTRIES = 8.
  - DAT address width = TASK_BITS + ENTRY_BITS.
- Sub-module `dat_arbiter`:
  - Combinational mux of the MMU path and this engine onto the SRAM pins.
  - The CPU path always has priority.
  - Lives beside this block; not instantiated inside it.
- Registers use the existing `register` primitive where a plain enable-load fits: the command latch and `hold`.

## Test plan
- FILL, ext = 0, dst = 12'h005, base = 16'h0038, no contention:
  - Expect low-byte writes to 0x0028..0x002F with 0x38..0x3F, `dat_we_h` = 0 throughout.
  - Expect `done` in cycle 9.
- FILL, ext = 1, base = 16'hFFFE:
  - Entries 0-7 receive FFFE, FFFF, 0000, ..., 0005. Confirms the wrap.
- COPY src = 1, dst = 2 with a preloaded SRAM model holding 0x1100..0x1107:
  - Task 2 equals task 1 after 16 cycles, with `done` in cycle 17.
- COPY with `cpu_req` high for 3 cycles during COPY_WR of idx 4:
  - No strobes in those cycles.
  - `hold` is preserved, no re-read of the source, and the correct value is written afterwards.
  - `done` arrives 3 cycles late.
- `reset` asserted after the 3rd FILL write:
  - Outputs go to their reset values the next cycle.
  - Entries 0-2 are written, entries 3-7 are untouched, and there is no `done`.
- `start` pulsed while busy, and again in the DONE cycle:
  - Both are ignored. Only one operation's writes are observed.
